// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma byte, lock depth and the rx FSM state set.
// Used by both the rx deserializer and the tx serializer.
package phy_pkg;

  localparam logic [7:0] COM_DEF        = 8'hBC;
  localparam int         SYNC_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_byte_align.sv
// Serial shift register, byte-phase counter and comma compare.
// The candidate byte always includes the bit on the current edge.
module phy_rx_byte_align
  import phy_pkg::*;
#(
  parameter logic [7:0] COM = COM_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_din,
  input  logic       i_search,
  output logic [7:0] o_byte,
  output logic       o_byte_done,
  output logic       o_com_hit
);

  logic [7:0] r_shreg;
  logic [2:0] r_bitcnt;

  assign o_byte      = {r_shreg[6:0], i_din};
  assign o_com_hit   = (o_byte == COM);
  assign o_byte_done = !i_search && (r_bitcnt == 3'd7);

  // Counter parks at 0 while hunting so the first aligned byte ends on 7.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_shreg <= o_byte;
      if (i_search)
        r_bitcnt <= '0;
      else
        r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Serial-to-32-bit receiver: comma lock, then 4-byte word assembly.
// COM bytes after lock are idles and abort any partial word.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter logic [7:0] COM        = COM_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in_serial,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        err
);

  localparam int CW = $clog2(SYNC_COUNT + 1);

  rx_state_e   r_state;
  logic [CW-1:0] r_com_cnt;
  logic [1:0]  r_k;
  logic [31:0] r_asm;

  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic        w_com_hit;
  logic        w_search;
  logic [1:0]  w_lane;

  assign w_search = (r_state == SEARCH);
  assign w_lane   = ~r_k;

  phy_rx_byte_align #(
    .COM(COM)
  ) u_align (
    .clk        (clk),
    .reset      (reset),
    .i_din      (data_in_serial),
    .i_search   (w_search),
    .o_byte     (w_byte),
    .o_byte_done(w_byte_done),
    .o_com_hit  (w_com_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_com_cnt <= '0;
      r_k       <= '0;
      r_asm     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      err       <= 1'b0;
      unique case (r_state)
        SEARCH: begin
          if (w_com_hit) begin
            r_com_cnt <= CW'(1);
            if (SYNC_COUNT <= 1) begin
              r_state <= ACTIVE;
              active  <= 1'b1;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (w_byte_done) begin
            if (w_com_hit) begin
              r_com_cnt <= r_com_cnt + CW'(1);
              if (int'(r_com_cnt) + 1 >= SYNC_COUNT) begin
                r_state <= ACTIVE;
                active  <= 1'b1;
              end
            end else begin
              r_com_cnt <= '0;
              r_state   <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          if (w_byte_done) begin
            if (w_com_hit) begin
              err   <= (r_k != 2'd0);
              r_k   <= '0;
              r_asm <= '0;
            end else begin
              r_k <= r_k + 2'd1;
              if (r_k == 2'd3) begin
                data_out  <= {r_asm[31:8], w_byte};
                valid_out <= 1'b1;
                r_asm     <= '0;
              end else begin
                r_asm[{w_lane, 3'b000} +: 8] <= w_byte;
              end
            end
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Scoreboard bench for phy_rx_deserializer: byte-level reference model,
// directed lock/idle/reset scenarios plus randomized traffic.
module tb_phy_rx_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_in_serial = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic        err;

  always #5 clk = ~clk;

  phy_rx_deserializer dut (
    .clk           (clk),
    .reset         (reset),
    .data_in_serial(data_in_serial),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .active        (active),
    .err           (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int err_seen = 0;
  int exp_err  = 0;
  int n_words  = 0;
  logic [31:0] exp_q[$];
  int vtimes[$];
  bit prev_v = 1'b0;

  // Reference model state, byte-granular.
  bit          m_lock;
  int          m_cnt;
  int          m_k;
  logic [7:0]  m_w[4];
  logic [31:0] m_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected words whenever the DUT presents one.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      check("valid_gap", 32'(prev_v), 32'd0);
      vtimes.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_word: got %h, expected no word", data_out);
      end else begin
        check("word", data_out, exp_q.pop_front());
      end
    end
    if (err) err_seen++;
    prev_v = valid_out;
  end

  task automatic m_byte(input logic [7:0] b);
    if (!m_lock) begin
      if (b == 8'hBC) begin
        m_cnt++;
        if (m_cnt == 4) m_lock = 1'b1;
      end else begin
        m_cnt = 0;
      end
    end else if (b == 8'hBC) begin
      if (m_k != 0) exp_err++;
      m_k = 0;
    end else begin
      m_w[m_k] = b;
      m_k++;
      if (m_k == 4) begin
        m_last = {m_w[0], m_w[1], m_w[2], m_w[3]};
        exp_q.push_back(m_last);
        n_words++;
        m_k = 0;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    data_in_serial = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_byte(b);
    check("active", 32'(active), 32'(m_lock));
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_in_serial = 1'b0;
    #1;
    check("rst_data", data_out, 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_lock = 1'b0;
    m_cnt  = 0;
    m_k    = 0;
    vtimes.delete();
  endtask

  task automatic lock_at_offset();
    int off;
    off = $urandom_range(0, 7);
    for (int i = 0; i < off; i++) send_bit(1'b0);
    send_rep(8'hBC, 4);
  endtask

  initial begin
    int e0;
    int w0;
    logic [7:0] b;

    // Power-on lock at random bit offset, one all-ones word.
    do_reset();
    lock_at_offset();
    check("lock_028", 32'(active), 32'd1);
    send_rep(8'hFF, 4);
    settle();
    check("nvalid_028", vtimes.size(), 32'd1);
    check("data_028", data_out, 32'hFFFFFFFF);

    // Back-to-back words, 32-cycle spacing.
    do_reset();
    send_rep(8'hBC, 4);
    send_rep(8'hEE, 4);
    send_rep(8'hDD, 4);
    settle();
    check("nvalid_029", vtimes.size(), 32'd2);
    if (vtimes.size() == 2)
      check("spacing_029", vtimes[1] - vtimes[0], 32'd32);

    // Broken comma run must not lock.
    do_reset();
    send_rep(8'hBC, 3);
    send_byte(8'h00);
    check("nolock_030", 32'(active), 32'd0);
    send_rep(8'hBC, 4);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    settle();
    check("data_030", data_out, 32'h00000003);

    // Idle mid-word: err pulse, word dropped.
    e0 = err_seen;
    w0 = vtimes.size();
    send_byte(8'hAA);
    send_byte(8'h99);
    send_byte(8'hBC);
    settle();
    check("err_031", err_seen - e0, 32'd1);
    check("noword_031", vtimes.size() - w0, 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    settle();
    check("data_031", data_out, 32'h11223344);

    // Reset mid-word: silent discard, full relock.
    e0 = err_seen;
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("err_032", err_seen - e0, 32'd0);
    send_rep(8'hBC, 4);
    send_rep(8'hCC, 4);
    send_rep(8'hBC, 2);
    settle();
    check("hold_032", data_out, 32'hCCCCCCCC);

    // Randomized traffic with sprinkled idles.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      lock_at_offset();
      for (int i = 0; i < 48; i++) begin
        if ($urandom_range(0, 5) == 0) b = 8'hBC;
        else b = 8'($urandom);
        send_byte(b);
      end
      settle();
      check("rand_qempty", exp_q.size(), 32'd0);
      check("rand_hold", data_out, m_last);
    end

    repeat (4) @(posedge clk);
    #1;
    check("err_total", err_seen, exp_err);
    check("q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit hit, expected $finish earlier");
    $fatal(1, "timeout");
  end

endmodule
